// File: rtl/updn_counter_mod.sv
// Modulo-MODULUS up/down counter with clear, clamped load, compare flag and cascade terminal count.
// Define UPDN_COUNTER_SATURATE_EN to hold at the range ends instead of wrapping (CO then never fires).
module updn_counter_mod #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             CLK,
   input  logic             MR_N,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic             EN,
   input  logic             UPDN,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] CMP,
   output logic [WIDTH-1:0] Q,
   output logic             CO,
   output logic             TC,
   output logic             MATCH
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

`ifdef UPDN_COUNTER_SATURATE_EN
   localparam bit SATURATE = 1'b1;
`else
   localparam bit SATURATE = 1'b0;
`endif

   logic [WIDTH-1:0] r_q;
   logic             r_co;
   logic             r_match;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_wrap;
   logic             w_at_max;
   logic             w_at_zero;

   assign w_at_max  = (r_q == MAX_VAL);
   assign w_at_zero = (r_q == '0);

   always_comb begin
      // NOTE: defaults first so every path assigns both signals; a missing branch would infer a latch.
      w_q_nxt = r_q;
      w_wrap  = 1'b0;
      if (CLR) begin
         w_q_nxt = '0;
      end else if (LOAD) begin
         // Out-of-range load data clamps; never true when MODULUS fills the register.
         w_q_nxt = (D > MAX_VAL) ? MAX_VAL : D;
      end else if (EN) begin
         if (UPDN) begin
            if (w_at_max) begin
               w_q_nxt = SATURATE ? MAX_VAL : '0;
               w_wrap  = ~SATURATE;
            end else begin
               w_q_nxt = r_q + ONE;
            end
         end else begin
            if (w_at_zero) begin
               w_q_nxt = SATURATE ? '0 : MAX_VAL;
               w_wrap  = ~SATURATE;
            end else begin
               w_q_nxt = r_q - ONE;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge MR_N) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!MR_N) begin
         r_q     <= '0;
         r_co    <= 1'b0;
         r_match <= 1'b0;
      end else begin
         r_q     <= w_q_nxt;
         r_co    <= w_wrap;
         r_match <= (w_q_nxt == CMP);
      end
   end

   assign Q     = r_q;
   assign CO    = r_co;
   assign MATCH = r_match;
   // Terminal count stays combinational so cascaded stages see it in the same cycle.
   assign TC    = EN & (UPDN ? w_at_max : w_at_zero);

endmodule

// File: tb/tb_updn_counter_mod.sv
// Self-checking bench for updn_counter_mod: vector table, corner sequences, and random run vs. a model.
// Honours UPDN_COUNTER_SATURATE_EN so the same bench covers both builds.
module tb_updn_counter_mod;

   localparam int W    = 4;
   localparam int MOD  = 10;
   localparam int WW   = 8;
   localparam int WMOD = 256;

`ifdef UPDN_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic          clk;
   logic          mr_n;
   logic          clr, load, en, updn;
   logic [W-1:0]  d, cmp, q;
   logic          co, tc, match;
   logic          wclr, wload, wen, wupdn;
   logic [WW-1:0] wd, wcmp, wq;
   logic          wco, wtc, wmatch;

   int n_pass  = 0;
   int n_total = 0;

   updn_counter_mod #(.WIDTH(W), .MODULUS(MOD)) u_dut (
      .CLK(clk), .MR_N(mr_n), .CLR(clr), .LOAD(load), .EN(en), .UPDN(updn),
      .D(d), .CMP(cmp), .Q(q), .CO(co), .TC(tc), .MATCH(match)
   );

   updn_counter_mod #(.WIDTH(WW), .MODULUS(WMOD)) u_wide (
      .CLK(clk), .MR_N(mr_n), .CLR(wclr), .LOAD(wload), .EN(wen), .UPDN(wupdn),
      .D(wd), .CMP(wcmp), .Q(wq), .CO(wco), .TC(wtc), .MATCH(wmatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       clr, load, en, updn;
      bit [3:0] d, cmp;
      bit [3:0] exp_q;
      bit       exp_co, exp_match;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input bit c, l, e, u, input int dd, cc, eq, eco, em);
      vec_t v;
      v.clr = c; v.load = l; v.en = e; v.updn = u;
      v.d = 4'(dd); v.cmp = 4'(cc); v.exp_q = 4'(eq);
      v.exp_co = eco[0]; v.exp_match = em[0];
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit c, l, e, u, input int dd, cc);
      clr = c; load = l; en = e; updn = u; d = 4'(dd); cmp = 4'(cc);
   endtask

   // Reference model: counts in plain integers over the range 0..MOD-1.
   int mq;
   bit mco, mmatch;

   task automatic model_edge(input bit c, l, e, u, input int dd, cc);
      int t;
      mco = 1'b0;
      if (c) mq = 0;
      else if (l) mq = (dd > MOD - 1) ? MOD - 1 : dd;
      else if (e) begin
         t = mq + (u ? 1 : -1);
         if (t < 0 || t >= MOD) begin
            if (!SAT) begin
               mq  = (t + MOD) % MOD;
               mco = 1'b1;
            end
         end else begin
            mq = t;
         end
      end
      mmatch = (mq == cc);
   endtask

   int up_q[4], up_co[4], up_tc[4];
   int dn_q[3], dn_co[3], dn_tc[3];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      if (SAT) begin
         up_q = '{9, 9, 9, 9}; up_co = '{0, 0, 0, 0}; up_tc = '{1, 1, 1, 1};
         dn_q = '{0, 0, 0};    dn_co = '{0, 0, 0};    dn_tc = '{1, 1, 1};
      end else begin
         up_q = '{9, 0, 1, 2}; up_co = '{0, 1, 0, 0}; up_tc = '{1, 0, 0, 0};
         dn_q = '{0, 9, 8};    dn_co = '{0, 1, 0};    dn_tc = '{1, 0, 0};
      end

      //           clr load en updn  d cmp  q co m
      vecs[0]  = mk(1, 0, 0, 0,  0, 0,  0, 0, 1);
      vecs[1]  = mk(0, 1, 0, 0, 10, 9,  9, 0, 1);
      vecs[2]  = mk(0, 1, 1, 1,  5, 0,  5, 0, 0);
      vecs[3]  = mk(1, 1, 0, 0,  7, 0,  0, 0, 1);
      vecs[4]  = mk(0, 0, 1, 1,  0, 0,  1, 0, 0);
      vecs[5]  = mk(0, 0, 1, 0,  0, 0,  0, 0, 1);
      vecs[6]  = mk(0, 0, 0, 1,  0, 0,  0, 0, 1);
      vecs[7]  = mk(0, 1, 0, 0, 15, 9,  9, 0, 1);
      vecs[8]  = mk(0, 0, 1, 0,  0, 9,  8, 0, 0);
      vecs[9]  = mk(0, 0, 0, 1,  0, 9,  8, 0, 0);
      vecs[10] = mk(0, 0, 1, 1,  0, 9,  9, 0, 1);
      vecs[11] = mk(0, 1, 0, 0,  9, 9,  9, 0, 1);

      mr_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      wclr = 0; wload = 0; wen = 0; wupdn = 0; wd = '0; wcmp = 8'd1;
      #2;
      check("reset_q", q, 0);
      check("reset_co", co, 0);
      check("reset_match", match, 0);
      step();
      mr_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].updn, vecs[i].d, vecs[i].cmp);
         step();
         check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
         check($sformatf("vec%0d_co", i), co, vecs[i].exp_co);
         check($sformatf("vec%0d_match", i), match, vecs[i].exp_match);
      end

      // Async reset from Q=7 with no edge, inputs ignored while held, resume on release.
      drive(0, 1, 0, 0, 7, 0);
      step();
      check("rst_pre_q", q, 7);
      drive(0, 1, 1, 1, 5, 0);
      mr_n = 1'b0;
      #1;
      check("rst_async_q", q, 0);
      check("rst_async_co", co, 0);
      check("rst_async_match", match, 0);
      for (int k = 0; k < 2; k++) begin
         step();
         check($sformatf("rst_hold%0d_q", k), q, 0);
         check($sformatf("rst_hold%0d_match", k), match, 0);
      end
      mr_n = 1'b1;
      drive(0, 0, 1, 1, 0, 0);
      step();
      check("rst_resume_q", q, 1);
      check("rst_resume_match", match, 0);

      // Reset during a CO pulse kills it immediately.
      drive(0, 1, 0, 0, 9, 0);
      step();
      drive(0, 0, 1, 1, 0, 0);
      step();
      check("abort_pre_q", q, SAT ? 9 : 0);
      check("abort_pre_co", co, SAT ? 0 : 1);
      mr_n = 1'b0;
      #1;
      check("abort_co", co, 0);
      check("abort_q", q, 0);
      step();
      mr_n = 1'b1;

      // Up count from 8 across the top of the range.
      drive(0, 1, 0, 0, 8, 0);
      step();
      drive(0, 0, 1, 1, 0, 0);
      #1;
      check("up_tc_at8", tc, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("up%0d_q", k), q, up_q[k]);
         check($sformatf("up%0d_co", k), co, up_co[k]);
         check($sformatf("up%0d_tc", k), tc, up_tc[k]);
      end

      // Down count from 1 across zero.
      drive(0, 1, 0, 0, 1, 0);
      step();
      drive(0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("dn%0d_q", k), q, dn_q[k]);
         check($sformatf("dn%0d_co", k), co, dn_co[k]);
         check($sformatf("dn%0d_tc", k), tc, dn_tc[k]);
      end

      // Compare flag aligned with Q, held while disabled.
      drive(1, 0, 0, 0, 0, 3);
      step();
      drive(0, 0, 1, 1, 0, 3);
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("match_up%0d_q", k), q, k);
         check($sformatf("match_up%0d_m", k), match, (k == 3) ? 1 : 0);
      end
      drive(0, 0, 0, 1, 0, 3);
      for (int k = 0; k < 2; k++) begin
         step();
         check($sformatf("match_hold%0d_q", k), q, 3);
         check($sformatf("match_hold%0d_m", k), match, 1);
      end
      drive(0, 0, 1, 1, 0, 3);
      step();
      check("match_leave_q", q, 4);
      check("match_leave_m", match, 0);

      // Full-range 8-bit instance: natural overflow.
      wd = 8'd255; wload = 1'b1;
      step();
      check("wide_load_q", wq, 255);
      wload = 1'b0; wen = 1'b1; wupdn = 1'b1;
      #1;
      check("wide_tc", wtc, 1);
      step();
      check("wide_wrap_q", wq, SAT ? 255 : 0);
      check("wide_wrap_co", wco, SAT ? 0 : 1);
      wen = 1'b0;
      step();
      check("wide_after_co", wco, 0);

      // Random run against the reference model.
      drive(1, 0, 0, 0, 0, 0);
      step();
      mq = 0; mco = 1'b0; mmatch = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bit rc, rl, re, ru;
         int rd, rcmp;
         rc   = ($urandom_range(0, 15) == 0);
         rl   = ($urandom_range(0, 7) == 0);
         re   = ($urandom_range(0, 3) != 0);
         ru   = $urandom_range(0, 1) == 1;
         rd   = $urandom_range(0, 15);
         rcmp = $urandom_range(0, 9);
         drive(rc, rl, re, ru, rd, rcmp);
         #1;
         check($sformatf("rnd%0d_tc", i), tc, (re && (ru ? (mq == MOD - 1) : (mq == 0))) ? 1 : 0);
         model_edge(rc, rl, re, ru, rd, rcmp);
         step();
         check($sformatf("rnd%0d_q", i), q, mq);
         check($sformatf("rnd%0d_co", i), co, mco);
         check($sformatf("rnd%0d_match", i), match, mmatch);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/updn_counter_mod.md
UPDN_COUNTER_MOD -- requirements
Module: updn_counter_mod

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning counter register width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 16, meaning count range 0..MODULUS-1; legal range is 2 <= MODULUS <= 2**WIDTH.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 The block SHALL have port MR_N, input, 1 bit: master reset, asynchronous, active-low.
REQ-005 The block SHALL have port CLR, input, 1 bit: synchronous clear, active-high.
REQ-006 The block SHALL have port LOAD, input, 1 bit: synchronous parallel load, active-high.
REQ-007 The block SHALL have port EN, input, 1 bit: count enable, active-high.
REQ-008 The block SHALL have port UPDN, input, 1 bit: count direction, 1 = up and 0 = down.
REQ-009 The block SHALL have port D, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port CMP, input, WIDTH bits: compare value.
REQ-011 The block SHALL have port Q, output, WIDTH bits: registered count.
REQ-012 The block SHALL have port CO, output, 1 bit: registered carry/borrow pulse.
REQ-013 The block SHALL have port TC, output, 1 bit: combinational terminal count, used for cascading.
REQ-014 The block SHALL have port MATCH, output, 1 bit: registered compare flag.

Function
REQ-015 Synchronous operations SHALL follow this priority, highest first: CLR, LOAD, EN count, hold.
REQ-016 When CLR=1, the block SHALL set Q to 0 on the next edge and clear CO.
REQ-017 When LOAD=1 and D <= MODULUS-1, the block SHALL set Q to D on the next edge, independent of EN and UPDN.
REQ-018 When LOAD=1 and D > MODULUS-1, the block SHALL set Q to MODULUS-1 (clamp).
REQ-019 When EN=1 and UPDN=1, the block SHALL set Q to Q+1, or to 0 when Q = MODULUS-1 (wrap).
REQ-020 When EN=1 and UPDN=0, the block SHALL set Q to Q-1, or to MODULUS-1 when Q = 0 (wrap).
REQ-021 Each count step SHALL have 1-cycle latency: a new Q value is visible immediately after the edge.
REQ-022 CO SHALL be high for exactly one cycle following an edge on which a wrap occurred, and low otherwise, including after a load or clear.
REQ-023 TC SHALL equal EN & (UPDN ? Q = MODULUS-1 : Q = 0), evaluated combinationally from current inputs and Q.
REQ-024 MATCH SHALL register (next Q = CMP) and therefore be aligned with Q.
REQ-025 When EN=0 with no CLR or LOAD, Q SHALL hold; a direction change takes effect on the next enabled edge with no extra latency.
REQ-026 When MODULUS = 2**WIDTH, wrap SHALL be the natural binary overflow/underflow, and the clamp in REQ-018 SHALL never apply.
REQ-027 Arithmetic SHALL be performed in WIDTH bits, and Q SHALL never hold a value above MODULUS-1.

Reset
REQ-028 MR_N=0 SHALL immediately force Q=0, CO=0, and MATCH=(CMP==0)?0:0, i.e. MATCH=0, with no clock required.
REQ-029 While MR_N=0, all synchronous inputs SHALL be ignored.
REQ-030 On the first rising edge after MR_N rises, the block SHALL operate normally.
REQ-031 An MR_N assertion mid-count SHALL abort any pending CO pulse.

Configuration
REQ-032 The block SHALL support the macro UPDN_COUNTER_SATURATE_EN.
REQ-033 When UPDN_COUNTER_SATURATE_EN is defined, counting up at MODULUS-1 SHALL hold at MODULUS-1, counting down at 0 SHALL hold at 0, and CO SHALL never assert.
REQ-034 When UPDN_COUNTER_SATURATE_EN is defined, TC SHALL remain as defined in REQ-023.
REQ-035 When UPDN_COUNTER_SATURATE_EN is undefined, the wrap behaviour of REQ-019, REQ-020 and REQ-022 SHALL apply.
REQ-036 The port list SHALL be identical in both builds.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-037 The bench SHALL cover: MR_N=0 for 2 cycles with Q previously 7 -> Q=0, CO=0, MATCH=0 with no clock edge needed; release -> counting resumes on the next edge.
REQ-038 The bench SHALL cover: LOAD=1, D=4'b1010 -> Q=9 (clamped); LOAD=1, D=5 with EN=1 -> Q=5 (load wins); CLR=1 together with LOAD=1 -> Q=0.
REQ-039 The bench SHALL cover: up count from Q=8 with EN=1 -> Q goes 9, 0, 1; CO high only in the cycle where Q=0; TC high while Q=9.
REQ-040 The bench SHALL cover: down count from Q=1 with EN=1 -> Q goes 0, 9, 8; CO high only in the cycle where Q=9; TC high while Q=0.
REQ-041 The bench SHALL cover: CMP=3, counting up from 0 -> MATCH high exactly in the cycle where Q=3; EN=0 at Q=3 -> Q and MATCH both held.
REQ-042 The bench SHALL cover: a build with UPDN_COUNTER_SATURATE_EN, counting up from 8 for 4 edges -> Q goes 9, 9, 9, 9 and CO stays 0; a build with WIDTH=8, MODULUS=256, counting up from 255 -> Q=0 and CO pulses.
